serial_sub: RTL and testbench

SERIAL_SUB -- requirements
Module: serial_sub

---
 rtl/serial_sub_if.sv | 22 ++
 rtl/serial_sub.sv | 103 ++++++++++
 tb/tb_serial_sub.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/serial_sub_if.sv
// Handshake/operand/result bundle for serial_sub.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input busy, done, diff, bout, ovf);
    modport slave  (input start, a, b, output busy, done, diff, bout, ovf);
`else
    modport master (output start, a, b, input busy, done, diff, bout);
    modport slave  (input start, a, b, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor, LSB first, one full-subtractor bit per clock.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow flag (bus.ovf).
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    serial_sub_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bit_d;
    logic             br_nxt;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Operand bit 0 is the current bit; the result fills from the MSB so that
    // after WIDTH shifts it is aligned and doubles as the held diff output.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        bit_d   = a_q[0] ^ b_q[0] ^ br_q;
        br_nxt  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = SHIFT;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {bit_d, res_q[WIDTH-1:1]};
                br_d  = br_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
`ifdef SERIAL_SUB_OVF_EN
                    // On the last bit, operand bit 0 holds each MSB and bit_d the diff MSB.
                    ovf_d = (a_q[0] ^ b_q[0]) & (a_q[0] ^ bit_d);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
    assign bus.diff = res_q;
    assign bus.bout = br_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_sub.sv
// Randomized self-checking bench for serial_sub against an arithmetic reference model.
module tb_serial_sub;
    localparam int W = 8;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    int exp_diff, exp_bout, exp_ovf;

    serial_sub_if #(.WIDTH(W)) bus ();
    serial_sub #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input int a, input int b);
        int sa, sb, r;
        exp_diff = (a - b) & MASK;
        exp_bout = (a < b) ? 1 : 0;
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        r  = sa - sb;
        exp_ovf = (r < -(1 << (W - 1)) || r > (1 << (W - 1)) - 1) ? 1 : 0;
    endtask

    // Present start with operands for one edge; returns at the negedge of SHIFT cycle 1.
    task automatic launch(input int a, input int b);
        bus.start = 1'b1;
        bus.a = a[W-1:0];
        bus.b = b[W-1:0];
        model(a, b);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Checks W busy cycles, then the done cycle; returns at the negedge inside DONE.
    task automatic track(input bit mid);
        for (int i = 0; i < W; i++) begin
            chk("busy", 32'(bus.busy), 32'd1);
            chk("done_early", 32'(bus.done), 32'd0);
            if (mid && i == 3) begin
                bus.start = 1'b1;
                bus.a = 8'hFF;
                bus.b = 8'h00;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("done", 32'(bus.done), 32'd1);
        chk("busy_in_done", 32'(bus.busy), 32'd0);
        chk("diff", 32'(bus.diff), 32'(exp_diff));
        chk("bout", 32'(bus.bout), 32'(exp_bout));
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", 32'(bus.ovf), 32'(exp_ovf));
`endif
    endtask

    // Leave DONE idle and confirm the result is held.
    task automatic settle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("done_pulse", 32'(bus.done), 32'd0);
            chk("busy_idle", 32'(bus.busy), 32'd0);
            chk("diff_hold", 32'(bus.diff), 32'(exp_diff));
            chk("bout_hold", 32'(bus.bout), 32'(exp_bout));
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        chk("rst_bout", 32'(bus.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        // start alongside rst must lose
        bus.start = 1'b1;
        bus.a = 8'h05;
        bus.b = 8'h03;
        @(negedge clk);
        bus.start = 1'b0;
        chk("rst_prio", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        launch(8'h05, 8'h03); track(1'b0); settle();
        launch(8'h00, 8'h01); track(1'b0); settle();
        launch(8'hAA, 8'hAA); track(1'b0); settle();
        launch(8'h80, 8'h01); track(1'b0); settle();
        launch(8'h5A, 8'h0F); track(1'b1); settle();
        // back-to-back: start held during DONE
        launch(8'h33, 8'h11); track(1'b0);
        launch(8'h10, 8'h20); track(1'b0); settle();

        // reset on the 4th SHIFT cycle aborts; no done afterwards
        launch(8'h5A, 8'h33);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_diff", 32'(bus.diff), 32'd0);
        chk("abort_bout", 32'(bus.bout), 32'd0);
        for (int i = 0; i < W + 3; i++) begin
            chk("abort_nodone", 32'(bus.done), 32'd0);
            @(negedge clk);
        end

        for (int n = 0; n < 60; n++) begin
            int ra, rb;
            ra = int'($urandom_range(0, MASK));
            rb = int'($urandom_range(0, MASK));
            launch(ra, rb);
            track(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) settle();
        end
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
